// File: rtl/down_timer_if.sv
// Control/status bundle for down_timer.
// Optional macro DOWN_TIMER_AUTO_RELOAD_EN adds the auto_reload request line.
interface down_timer_if #(
  parameter int WIDTH = 4
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_value;
  logic             start;
  logic             pause;
  logic             abort;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
  logic             auto_reload;
`endif
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             tc;

  // Requester side: drives loads and run controls, observes the timer.
  modport master (
    output load_valid, load_value, start, pause, abort,
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
    output auto_reload,
`endif
    input  load_ready, count, busy, tc
  );

  // Timer side.
  modport slave (
    input  load_valid, load_value, start, pause, abort,
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
    input  auto_reload,
`endif
    output load_ready, count, busy, tc
  );
endinterface

// File: rtl/down_timer.sv
// Loadable, pausable down-counting timer with a one-cycle terminal-count pulse.
// Optional macro DOWN_TIMER_AUTO_RELOAD_EN: when defined, a terminal edge with
// auto_reload=1 reloads the last loaded value and keeps running (periodic tc).
module down_timer #(
  parameter int WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  down_timer_if.slave  tmr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;

  logic load_ready;
  logic load_acc;
  logic auto_rl;

  // Loads are only taken while the counter is not running.
  assign load_ready = (state_q != RUN);
  assign load_acc   = tmr.load_valid && load_ready;

`ifdef DOWN_TIMER_AUTO_RELOAD_EN
  assign auto_rl = tmr.auto_reload;
`else
  assign auto_rl = 1'b0;
`endif

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  // Next-state and datapath decode.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_acc) begin
          // load beats a simultaneous start
          count_d  = tmr.load_value;
          reload_d = tmr.load_value;
        end else if (tmr.start && (count_q != '0)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (tmr.abort) begin
          // stop without touching the count; a later start resumes from here
          state_d = IDLE;
        end else if (!tmr.pause) begin
          if (count_q == WIDTH'(1)) begin
            tc_d = 1'b1;
            if (auto_rl) begin
              count_d = reload_q;
            end else begin
              count_d = '0;
              state_d = DONE;
            end
          end else if (count_q != '0) begin
            // zero cannot be reached here in normal use; never wrap
            count_d = count_q - WIDTH'(1);
          end
        end
      end
      DONE: begin
        if (load_acc) begin
          count_d  = tmr.load_value;
          reload_d = tmr.load_value;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign tmr.load_ready = load_ready;
  assign tmr.busy       = (state_q == RUN);
  assign tmr.count      = count_q;
  assign tmr.tc         = tc_q;

endmodule

// File: tb/tb_down_timer.sv
// Directed self-checking bench for down_timer.
module tb_down_timer;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;

  down_timer_if #(.WIDTH(W)) tif ();

  down_timer #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .tmr (tif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // advance one edge; outputs are sampled 1ns after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [W-1:0] v);
    tif.load_valid = 1'b1;
    tif.load_value = v;
    step();
    tif.load_valid = 1'b0;
  endtask

  task automatic go();
    tif.start = 1'b1;
    step();
    tif.start = 1'b0;
  endtask

  initial begin
    tif.load_valid = 1'b0;
    tif.load_value = '0;
    tif.start      = 1'b0;
    tif.pause      = 1'b0;
    tif.abort      = 1'b0;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
    tif.auto_reload = 1'b0;
`endif

    // 1. reset state
    repeat (2) step();
    chk("rst_count", tif.count, 0);
    chk("rst_busy",  tif.busy, 0);
    chk("rst_tc",    tif.tc, 0);
    chk("rst_ready", tif.load_ready, 1);
    rst = 1'b0;

    // 2. load 5, run to terminal
    load(5);
    chk("s2_load_count", tif.count, 5);
    chk("s2_load_busy",  tif.busy, 0);
    go();
    chk("s2_start_count", tif.count, 5);
    chk("s2_start_busy",  tif.busy, 1);
    chk("s2_start_ready", tif.load_ready, 0);
    for (int i = 4; i >= 1; i--) begin
      step();
      chk("s2_dec_count", tif.count, i);
      chk("s2_dec_tc",    tif.tc, 0);
    end
    step();
    chk("s2_term_count", tif.count, 0);
    chk("s2_term_tc",    tif.tc, 1);
    chk("s2_term_busy",  tif.busy, 0);
    chk("s2_term_ready", tif.load_ready, 1);
    step();
    chk("s2_done_tc",    tif.tc, 0);
    chk("s2_done_count", tif.count, 0);
    go();
    chk("s2_done_start_busy", tif.busy, 0);

    // 3. pause for 3 cycles after first decrement
    load(4);
    go();
    step();
    chk("s3_first_dec", tif.count, 3);
    tif.pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("s3_pause_count", tif.count, 3);
      chk("s3_pause_busy",  tif.busy, 1);
    end
    tif.pause = 1'b0;
    step(); chk("s3_c2", tif.count, 2); chk("s3_tc_early", tif.tc, 0);
    step(); chk("s3_c1", tif.count, 1); chk("s3_tc_early", tif.tc, 0);
    step(); chk("s3_c0", tif.count, 0); chk("s3_tc", tif.tc, 1);

    // 4. boundaries
    load(0);
    go();
    chk("s4_zero_start_busy", tif.busy, 0);
    tif.load_valid = 1'b1;
    tif.load_value = 6;
    tif.start      = 1'b1;
    step();
    tif.load_valid = 1'b0;
    tif.start      = 1'b0;
    chk("s4_ld_st_count", tif.count, 6);
    chk("s4_ld_st_busy",  tif.busy, 0);
    go();
    tif.load_valid = 1'b1;
    tif.load_value = 9;
    step();
    chk("s4_run_ready", tif.load_ready, 0);
    chk("s4_run_count", tif.count, 5);
    step();
    chk("s4_run_count2", tif.count, 4);
    tif.load_valid = 1'b0;
    tif.abort = 1'b1;
    step();
    tif.abort = 1'b0;
    chk("s4_abort_busy",  tif.busy, 0);
    chk("s4_abort_count", tif.count, 4);

    // 5. abort at count 2 (with pause also high: abort wins), then resume
    load(5);
    go();
    step(); step(); step();
    chk("s5_pre_abort", tif.count, 2);
    tif.abort = 1'b1;
    tif.pause = 1'b1;
    step();
    tif.abort = 1'b0;
    tif.pause = 1'b0;
    chk("s5_abort_busy",  tif.busy, 0);
    chk("s5_abort_count", tif.count, 2);
    chk("s5_abort_tc",    tif.tc, 0);
    go();
    chk("s5_resume_busy", tif.busy, 1);
    chk("s5_resume_count", tif.count, 2);
    step(); chk("s5_c1", tif.count, 1); chk("s5_tc_early", tif.tc, 0);
    step(); chk("s5_c0", tif.count, 0); chk("s5_tc", tif.tc, 1);

    // 1b. asynchronous reset mid-run at count 3
    load(5);
    go();
    step(); step();
    chk("s1_pre_rst", tif.count, 3);
    #2 rst = 1'b1;
    #1;
    chk("s1_async_count", tif.count, 0);
    chk("s1_async_busy",  tif.busy, 0);
    chk("s1_async_ready", tif.load_ready, 1);
    step();
    rst = 1'b0;

`ifdef DOWN_TIMER_AUTO_RELOAD_EN
    // 6. periodic terminal count
    tif.auto_reload = 1'b1;
    load(3);
    go();
    for (int r = 0; r < 2; r++) begin
      step(); chk("s6_c2", tif.count, 2); chk("s6_tc_lo", tif.tc, 0);
      step(); chk("s6_c1", tif.count, 1);
      step(); chk("s6_reload", tif.count, 3); chk("s6_tc", tif.tc, 1);
      chk("s6_busy", tif.busy, 1);
    end
    tif.auto_reload = 1'b0;
    step(); step(); step();
    chk("s6_final_count", tif.count, 0);
    chk("s6_final_tc",    tif.tc, 1);
    chk("s6_final_busy",  tif.busy, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
